// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter and byte sequencer that shares one uart_transmitter
// between N_REQ packet sources. One requester holds the grant until its byte
// flagged last has been sent. Each byte is fetched (acked), written with a
// one-cycle tx_wr pulse, and paced on tx_busy. The transmitter start is
// supervised by a timeout, and GAP_CYCLES idle cycles follow every byte.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   sched_en     scheduler enable; low aborts to IDLE on the next edge
//   req          per-requester byte valid / packet pending
//   req_data     byte of requester i at [8i+7:8i]
//   req_last     presented byte is the last of its packet
//   grant        one-hot owner of the transmitter
//   ack          one-cycle pulse: granted requester's byte captured
//   tx_data      byte to transmitter, held stable
//   tx_wr        one-cycle write strobe to transmitter
//   tx_en        transmitter enable, sched_en delayed by one cycle
//   tx_busy      transmitter busy
//   sched_busy   high whenever the scheduler is not idle
//   timeout_err  one-cycle pulse when the transmitter failed to start
//
// Per byte: FETCH (ack, tx_data load) -> WRITE (tx_wr high) -> WAIT_START
// -> WAIT_DONE -> GAP. timeout_err rises START_TIMEOUT cycles after the edge
// that leaves WRITE. The next tx_wr of a packet follows GAP_CYCLES + 2 cycles
// after the first tx_busy-low cycle (WAIT_DONE detect, GAP, FETCH).
module uart_tx_scheduler #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned GAP_CYCLES    = 2,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sched_en,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           tx_data,
    output logic                 tx_wr,
    output logic                 tx_en,
    input  logic                 tx_busy,
    output logic                 sched_busy,
    output logic                 timeout_err
);

    localparam int unsigned PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TO_LAST  = (START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned CNT_MAX  = (TO_LAST > GAP_LAST) ? TO_LAST : GAP_LAST;
    localparam int unsigned CW       = $clog2(CNT_MAX + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_FETCH,
        S_WRITE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          state, state_d;
    logic [PW-1:0]   ptr, ptr_d;
    logic [PW-1:0]   winner, winner_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [N_REQ-1:0] grant_d, ack_d;
    logic [7:0]      tx_data_d;
    logic            tx_wr_d, timeout_err_d, sched_busy_d;
    logic [PW-1:0]   pick, nxt;

    // First set request at or above the pointer, wrapping to 0.
    function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [PW-1:0]    p);
        logic [PW-1:0] w;
        logic          found;
        int unsigned   j;
        w     = p;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = 32'(p) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && r[PW'(j)]) begin
                w     = PW'(j);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign pick = rr_pick(req, ptr);
    assign nxt  = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            winner      <= '0;
            last_q      <= 1'b0;
            cnt         <= '0;
            grant       <= '0;
            ack         <= '0;
            tx_data     <= 8'hFF;
            tx_wr       <= 1'b0;
            tx_en       <= 1'b0;
            sched_busy  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            winner      <= winner_d;
            last_q      <= last_d;
            cnt         <= cnt_d;
            grant       <= grant_d;
            ack         <= ack_d;
            tx_data     <= tx_data_d;
            tx_wr       <= tx_wr_d;
            tx_en       <= sched_en;
            sched_busy  <= sched_busy_d;
            timeout_err <= timeout_err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        ptr_d         = ptr;
        winner_d      = winner;
        last_d        = last_q;
        cnt_d         = cnt;
        grant_d       = grant;
        ack_d         = '0;
        tx_data_d     = tx_data;
        tx_wr_d       = 1'b0;
        timeout_err_d = 1'b0;

        if (!sched_en) begin
            // Abort: pointer kept, in-flight byte is not re-acked.
            state_d = S_IDLE;
            grant_d = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) state_d = S_ARB;
                end
                S_ARB: begin
                    if (|req) begin
                        winner_d       = pick;
                        grant_d        = '0;
                        grant_d[pick]  = 1'b1;
                        state_d        = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (req[winner]) begin
                        tx_data_d      = req_data[{winner, 3'b000} +: 8];
                        last_d         = req_last[winner];
                        ack_d[winner]  = 1'b1;
                        tx_wr_d        = 1'b1;
                        state_d        = S_WRITE;
                    end else begin
                        // Requester withdrew mid-packet.
                        grant_d = '0;
                        ptr_d   = nxt;
                        state_d = S_IDLE;
                    end
                end
                S_WRITE: begin
                    cnt_d   = '0;
                    state_d = S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (tx_busy) begin
                        state_d = S_WAIT_DONE;
                    end else if (cnt == CW'(TO_LAST)) begin
                        timeout_err_d = 1'b1;
                        grant_d       = '0;
                        ptr_d         = nxt;
                        state_d       = S_IDLE;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    // Zero gap still spends one cycle here.
                    if (GAP_CYCLES == 0 || cnt == CW'(GAP_LAST)) begin
                        if (!last_q) begin
                            state_d = S_FETCH;
                        end else begin
                            grant_d = '0;
                            ptr_d   = nxt;
                            state_d = (|req) ? S_ARB : S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        sched_busy_d = (state_d != S_IDLE);
    end

endmodule
